// File: rtl/debounce_sync_if.sv
// Debounce pin bundle: raw level in, clean level plus edge strobes and busy out.
//   d_raw : raw asynchronous input level (driven by master)
//   q     : debounced level
//   rise  : one-cycle strobe when q goes 0->1
//   fall  : one-cycle strobe when q goes 1->0
//   busy  : a candidate transition is being qualified
interface debounce_sync_if;
    logic d_raw;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output d_raw,
        input  q,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  d_raw,
        output q,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchronise and debounce an asynchronous level input.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   dbif   : slave side of debounce_sync_if (d_raw in; q, rise, fall, busy out,
//            all outputs registered)
// q follows the synchronised input only after STABLE_CYCLES consecutive equal
// samples; rise/fall pulse for one cycle coincident with the q edge.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    debounce_sync_if.slave   dbif
);

    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    // Reject illegal parameterisations at elaboration.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
    end
    if (STABLE_CYCLES < 2 || 64'(STABLE_CYCLES) > CNT_MAX) begin : g_bad_stable
        $error("debounce_sync: STABLE_CYCLES=%0d outside 2..2**CNT_W-1", STABLE_CYCLES);
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;

    logic                   w_s;
    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_q_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   w_busy_nxt;

    // Synchroniser chain; only the last stage is seen by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], dbif.d_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // FSM, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state: a WAIT state counts consecutive opposite samples and falls
    // back to its IDLE state on any sample matching the current q.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_q_nxt     = r_q;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            IDLE_LOW: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = IDLE_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_q_nxt     = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    w_state_nxt = IDLE_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_q_nxt     = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_q_nxt     = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
    end

    assign dbif.q    = r_q;
    assign dbif.rise = r_rise;
    assign dbif.fall = r_fall;
    assign dbif.busy = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed plan steps followed by random bouncing,
// all checked against a window-based reference model.
module tb_debounce_sync;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 4;
    localparam int unsigned CNTW   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    debounce_sync_if dbif ();

    debounce_sync #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (CNTW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbif  (dbif)
    );

    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;
    int unsigned n_total  = 0;
    int unsigned rise_cnt = 0;
    int unsigned fall_cnt = 0;

    // Reference: s is d_raw delayed SYNC edges; q flips once the last STABLE
    // samples of s all differ from q; busy means the newest s differs from q.
    bit m_pipe[$];
    bit m_win[$];
    bit m_q, m_rise, m_fall, m_busy;

    function automatic void m_reset();
        m_pipe.delete();
        for (int i = 0; i < int'(SYNC); i++) m_pipe.push_back(1'b0);
        m_win.delete();
        m_q    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
    endfunction

    function automatic void m_edge(bit d);
        bit s;
        bit all_opp;
        s = m_pipe.pop_front();
        m_pipe.push_back(d);
        m_win.push_back(s);
        if (m_win.size() > int'(STABLE)) void'(m_win.pop_front());
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (m_win.size() == int'(STABLE)) begin
            all_opp = 1'b1;
            foreach (m_win[i]) if (m_win[i] == m_q) all_opp = 1'b0;
            if (all_opp) begin
                m_q = !m_q;
                if (m_q) m_rise = 1'b1;
                else     m_fall = 1'b1;
            end
        end
        m_busy = (s != m_q);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    dbif.q,    m_q);
        chk({tag, ".rise"}, dbif.rise, m_rise);
        chk({tag, ".fall"}, dbif.fall, m_fall);
        chk({tag, ".busy"}, dbif.busy, m_busy);
    endtask

    // One clock: drive d, let the edge happen, step the model, then check.
    task automatic cyc(input bit d, input string tag);
        dbif.d_raw = d;
        @(posedge clk);
        if (rst_n) m_edge(d);
        #1;
        check_all(tag);
        if (dbif.rise === 1'b1) rise_cnt++;
        if (dbif.fall === 1'b1) fall_cnt++;
    endtask

    // Assert reset between edges and confirm the outputs clear at once.
    task automatic assert_reset(input string tag);
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all(tag);
    endtask

    task automatic hold(input bit d, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(d, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lvl;
        int run;

        // 1. Reset held with d_raw=1, then release.
        dbif.d_raw = 1'b1;
        rst_n      = 1'b0;
        m_reset();
        hold(1'b1, 5, "t1_in_reset");
        rst_n    = 1'b1;
        rise_cnt = 0;
        hold(1'b1, 5, "t1_release");
        chk("t1_q_before_e6", dbif.q, 1'b0);
        cyc(1'b1, "t1_e6");
        chk("t1_q_e6", dbif.q, 1'b1);
        chk("t1_rise_e6", dbif.rise, 1'b1);
        cyc(1'b1, "t1_e7");
        chk("t1_rise_e7", dbif.rise, 1'b0);

        // 2. Clean rise from a fresh low reset.
        assert_reset("t2_rst");
        hold(1'b0, 2, "t2_in_reset");
        rst_n = 1'b1;
        hold(1'b0, 3, "t2_idle");
        rise_cnt = 0;
        fall_cnt = 0;
        cyc(1'b1, "t2_e1");
        cyc(1'b1, "t2_e2");
        chk("t2_busy_e2", dbif.busy, 1'b0);
        cyc(1'b1, "t2_e3");
        chk("t2_busy_e3", dbif.busy, 1'b1);
        hold(1'b1, 2, "t2_e4_5");
        cyc(1'b1, "t2_e6");
        chk("t2_q_e6", dbif.q, 1'b1);
        chk("t2_rise_e6", dbif.rise, 1'b1);
        cyc(1'b1, "t2_e7");
        chk("t2_rise_e7", dbif.rise, 1'b0);
        chk("t2_busy_e7", dbif.busy, 1'b0);
        chk("t2_no_fall", logic'(fall_cnt == 0), 1'b1);

        // 5. Fall path from q=1.
        rise_cnt = 0;
        hold(1'b0, 5, "t5_e1_5");
        chk("t5_q_e5", dbif.q, 1'b1);
        cyc(1'b0, "t5_e6");
        chk("t5_q_e6", dbif.q, 1'b0);
        chk("t5_fall_e6", dbif.fall, 1'b1);
        cyc(1'b0, "t5_e7");
        chk("t5_fall_e7", dbif.fall, 1'b0);
        chk("t5_no_rise", logic'(rise_cnt == 0), 1'b1);
        hold(1'b0, 2, "t5_settle");

        // 3. Glitch of STABLE-1 samples rejected, STABLE samples accepted.
        rise_cnt = 0;
        hold(1'b1, 3, "t3_short_hi");
        hold(1'b0, 6, "t3_short_lo");
        chk("t3_short_q", dbif.q, 1'b0);
        chk("t3_short_busy", dbif.busy, 1'b0);
        chk("t3_short_norise", logic'(rise_cnt == 0), 1'b1);
        hold(1'b1, 4, "t3_long_hi");
        hold(1'b0, 1, "t3_long_e5");
        cyc(1'b0, "t3_long_e6");
        chk("t3_long_q_e6", dbif.q, 1'b1);
        chk("t3_long_rise", logic'(rise_cnt == 1), 1'b1);
        hold(1'b0, 8, "t3_back_low");
        chk("t3_back_low_q", dbif.q, 1'b0);

        // 4. Bounce 1,0,1,1,0,1 then hold 1.
        rise_cnt = 0;
        cyc(1'b1, "t4_b");
        cyc(1'b0, "t4_b");
        cyc(1'b1, "t4_b");
        cyc(1'b1, "t4_b");
        cyc(1'b0, "t4_b");
        cyc(1'b1, "t4_final_e1");
        hold(1'b1, 4, "t4_e2_5");
        chk("t4_q_e5", dbif.q, 1'b0);
        cyc(1'b1, "t4_e6");
        chk("t4_q_e6", dbif.q, 1'b1);
        hold(1'b1, 4, "t4_tail");
        chk("t4_one_rise", logic'(rise_cnt == 1), 1'b1);

        // 6. Reset during WAIT_HIGH with the count at 2.
        hold(1'b0, 8, "t6_to_low");
        rise_cnt = 0;
        hold(1'b1, 4, "t6_qual");
        chk("t6_busy_before", dbif.busy, 1'b1);
        assert_reset("t6_async");
        chk("t6_busy_cleared", dbif.busy, 1'b0);
        hold(1'b1, 2, "t6_in_reset");
        chk("t6_norise", logic'(rise_cnt == 0), 1'b1);
        rst_n = 1'b1;
        hold(1'b1, 5, "t6_restart");
        chk("t6_q_e5", dbif.q, 1'b0);
        cyc(1'b1, "t6_e6");
        chk("t6_q_e6", dbif.q, 1'b1);

        // Random bouncing with run lengths straddling the threshold.
        lvl = 1'b0;
        for (int k = 0; k < 120; k++) begin
            run = int'($urandom_range(1, 7));
            lvl = !lvl;
            hold(lvl, run, "rand");
        end
        hold(lvl, 8, "rand_settle");
        chk("rand_final_q", dbif.q, logic'(lvl));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
